vec_cache_wdb_port_sched: RTL
=============================

# vec_cache_wdb_port_sched

Cycle-by-cycle scheduler for the single-port write data buffer (WDB) SRAM. It shares one RAM port between one drain requester and FILL_REQ_NUM fill requesters:
- The drain requester reads a buffered entry out toward the data RAM.
- The fill requesters write incoming write data into pre-allocated entries.

The block tracks which entries hold valid data, prevents drains of empty entries, and bounds fill starvation. It sits between the write-data ingress and the WDB RAM instance, next to the WDB entry allocator.

## Interface
Parameters:
- ENTRY_NUM, 16, WDB entry count (power of 2, ≥2); IDX_W = $clog2(ENTRY_NUM)
- FILL_REQ_NUM, 4, fill requester count (≥1); SEL_W = max(1,$clog2(FILL_REQ_NUM))
- STARVE_LIMIT, 8, consecutive drain-won cycles with a fill pending before fill is forced (≥1)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- fill_vld  in  FILL_REQ_NUM  per-requester fill request
- fill_idx  in  FILL_REQ_NUM*IDX_W  per-requester target entry, requester i at [i*IDX_W +: IDX_W]
- fill_rdy  out  FILL_REQ_NUM  one-hot fill grant
- drain_vld  in  1  drain request
- drain_idx  in  IDX_W  entry to drain
- drain_rdy  out  1  drain grant
- mem_en  out  1  RAM enable
- mem_wr_en  out  1  1=write (fill), 0=read (drain)
- mem_addr  out  IDX_W  RAM address
- mem_wr_sel  out  SEL_W  index of the granted fill requester; steers the write-data mux
- rd_data_vld  out  1  RAM read data valid this cycle
- rd_data_idx  out  IDX_W  entry whose data is on the RAM output
- filled  out  ENTRY_NUM  per-entry valid-data bitmap
- filled_cnt  out  IDX_W+1  popcount of filled
- err_fill_dup  out  1  pulse: fill granted to an entry already filled
- starve_force  out  1  fill priority forced this cycle

## Operation
- Port model: at most one RAM access per cycle, so a fill grant and a drain grant are mutually exclusive.
- Drain eligibility: drain_elig = drain_vld & filled[drain_idx]. A drain of an unfilled entry stalls with drain_rdy=0 and does not block fills.
- Priority:
  - Normally drain_elig wins over any fill.
  - When starve_cnt == STARVE_LIMIT and |fill_vld, fill wins: starve_force=1, drain_rdy=0.
- Fill arbitration: round-robin over fill_vld, starting at rr_ptr.
  - On a fill grant to requester g, rr_ptr <= (g+1) mod FILL_REQ_NUM.
  - rr_ptr is unchanged with no fill grant.
- starve_cnt update (saturates at STARVE_LIMIT):
  - Drain granted while |fill_vld: increment.
  - Fill granted, or no fill pending: clear to 0.
- Grant outputs (combinational from current inputs and state):
  - mem_en = fill grant | drain grant.
  - mem_wr_en = fill grant.
  - mem_addr = granted fill_idx or drain_idx.
  - mem_wr_sel = g; 0 when no fill grant.
- filled bitmap:
  - Fill grant sets filled[fill_idx[g]].
  - Drain grant clears filled[drain_idx].
  - No same-cycle conflict exists, because grants are exclusive.
- err_fill_dup: registered pulse in the cycle after a fill grant whose target was already filled. The write still proceeds (overwrite) and filled stays 1.
- filled_cnt: registered; +1 on a fill to an empty entry, -1 on a drain, unchanged otherwise.

## Timing
- Fill write commits at the grant edge, so the entry is drain-eligible on the next cycle.
- Read latency is 1:
  - rd_data_vld and rd_data_idx are registered from the drain grant and are high exactly one cycle after the drain_vld&drain_rdy cycle.
  - This aligns with the RAM's registered rd_data.
- Back-to-back drains are supported at full rate (one per cycle).
- Handshake rules:
  - Requesters hold vld and idx until rdy; the block never withdraws a grant.
  - fill_rdy[i] is never asserted without fill_vld[i].
- Reset values: all registered outputs 0 (rd_data_vld, rd_data_idx, filled, filled_cnt, err_fill_dup); starve_cnt 0; rr_ptr 0.
  - Combinational outputs during reset: fill_rdy, drain_rdy, mem_en, mem_wr_en, mem_addr, mem_wr_sel and starve_force are all 0.
  - drain_rdy=0 follows from filled=0.
- Reset mid-operation: all state clears asynchronously and any in-flight rd_data_vld is dropped.
- Boundaries:
  - filled_cnt == ENTRY_NUM is legal.
  - rr_ptr wraps FILL_REQ_NUM-1 -> 0.
  - STARVE_LIMIT=1 alternates drain/fill under continuous contention.

## Test plan
- Fill then drain: fill_vld[0]=1, idx=3, granted in cycle t. Drain idx 3 at t+1. Required: rd_data_vld=1 at t+2 with rd_data_idx=3; filled[3] is 0 after the drain; filled_cnt goes 0->1->0.
- Drain of an empty entry: drain_vld=1, idx=5, filled[5]=0, fill_vld[2]=1. Required: fill_rdy=4'b0100, drain_rdy=0; the drain is granted the cycle after entry 5 is filled.
- Round-robin: all four fill_vld held, distinct idx, no drain. Required: grant order 0,1,2,3,0; mem_wr_sel matches the grant.
- Starvation bound: STARVE_LIMIT=8, continuous eligible drains with fill_vld[1] held. Required: 8 drain grants, then in cycle 9 starve_force=1, fill_rdy[1]=1, drain_rdy=0; drains resume after.
- Duplicate fill: fill entry 7 twice. Required: err_fill_dup pulses once, one cycle after the second grant; filled_cnt stays 1.
- Reset mid-stream: assert rst_n low the cycle after a drain grant. Required: rd_data_vld=0 immediately; filled=0; filled_cnt=0; grant outputs 0 while in reset.

Source files
------------

// File: rtl/vec_cache_wdb_port_sched.sv
// Shares the single WDB SRAM port between one drain requester and FILL_REQ_NUM fill requesters.
// Grants are combinational; read data is valid one cycle after a drain grant.
module vec_cache_wdb_port_sched #(
  parameter  int ENTRY_NUM    = 16,
  parameter  int FILL_REQ_NUM = 4,
  parameter  int STARVE_LIMIT = 8,
  localparam int IDX_W        = $clog2(ENTRY_NUM),
  localparam int SEL_W        = (FILL_REQ_NUM > 1) ? $clog2(FILL_REQ_NUM) : 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [FILL_REQ_NUM-1:0]       fill_vld,
  input  logic [FILL_REQ_NUM*IDX_W-1:0] fill_idx,
  output logic [FILL_REQ_NUM-1:0]       fill_rdy,
  input  logic                          drain_vld,
  input  logic [IDX_W-1:0]              drain_idx,
  output logic                          drain_rdy,
  output logic                          mem_en,
  output logic                          mem_wr_en,
  output logic [IDX_W-1:0]              mem_addr,
  output logic [SEL_W-1:0]              mem_wr_sel,
  output logic                          rd_data_vld,
  output logic [IDX_W-1:0]              rd_data_idx,
  output logic [ENTRY_NUM-1:0]          filled,
  output logic [IDX_W:0]                filled_cnt,
  output logic                          err_fill_dup,
  output logic                          starve_force
);

  localparam int                   STARVE_W   = $clog2(STARVE_LIMIT + 1);
  localparam logic [STARVE_W-1:0]  STARVE_MAX = STARVE_W'(STARVE_LIMIT);
  localparam logic [SEL_W-1:0]     SEL_LAST   = SEL_W'(FILL_REQ_NUM - 1);
  localparam logic [SEL_W-1:0]     SEL_ONE    = SEL_W'(1);
  localparam logic [STARVE_W-1:0]  STARVE_ONE = STARVE_W'(1);
  localparam logic [IDX_W:0]       CNT_ONE    = (IDX_W+1)'(1);

  logic [ENTRY_NUM-1:0] r_filled;
  logic [IDX_W:0]       r_filled_cnt;
  logic [SEL_W-1:0]     r_rr_ptr;
  logic [STARVE_W-1:0]  r_starve_cnt;
  logic                 r_rd_vld;
  logic [IDX_W-1:0]     r_rd_idx;
  logic                 r_err_dup;

  logic                 w_fill_pend;
  logic                 w_found;
  logic [SEL_W-1:0]     w_cand;
  logic [SEL_W-1:0]     w_fill_sel;
  logic [IDX_W-1:0]     w_fill_tgt;
  logic                 w_drain_elig;
  logic                 w_force;
  logic                 w_fill_gnt;
  logic                 w_drain_gnt;

  // Round-robin search starting at r_rr_ptr; first requesting index wins.
  always_comb begin
    w_fill_pend = |fill_vld;
    w_found     = 1'b0;
    w_cand      = '0;
    w_fill_sel  = '0;
    for (int k = 0; k < FILL_REQ_NUM; k++) begin
      w_cand = SEL_W'((int'(r_rr_ptr) + k) % FILL_REQ_NUM);
      if (!w_found && fill_vld[w_cand]) begin
        w_found    = 1'b1;
        w_fill_sel = w_cand;
      end
    end
  end

  assign w_fill_tgt   = fill_idx[w_fill_sel*IDX_W +: IDX_W];
  assign w_drain_elig = drain_vld & r_filled[drain_idx];
  assign w_force      = (r_starve_cnt == STARVE_MAX) & w_fill_pend;

  // rst_n gating keeps every grant output quiet while reset is held.
  assign w_fill_gnt   = rst_n & w_fill_pend & (~w_drain_elig | w_force);
  assign w_drain_gnt  = rst_n & w_drain_elig & ~w_force;

  assign fill_rdy     = w_fill_gnt ? (FILL_REQ_NUM'(1) << w_fill_sel) : '0;
  assign drain_rdy    = w_drain_gnt;
  assign starve_force = rst_n & w_force;
  assign mem_en       = w_fill_gnt | w_drain_gnt;
  assign mem_wr_en    = w_fill_gnt;
  assign mem_wr_sel   = w_fill_gnt ? w_fill_sel : '0;

  always_comb begin
    mem_addr = '0;
    if (w_fill_gnt)       mem_addr = w_fill_tgt;
    else if (w_drain_gnt) mem_addr = drain_idx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_filled     <= '0;
      r_filled_cnt <= '0;
      r_rr_ptr     <= '0;
      r_starve_cnt <= '0;
      r_rd_vld     <= 1'b0;
      r_rd_idx     <= '0;
      r_err_dup    <= 1'b0;
    end else begin
      r_rd_vld  <= w_drain_gnt;
      r_err_dup <= w_fill_gnt & r_filled[w_fill_tgt];
      if (w_drain_gnt) begin
        r_rd_idx <= drain_idx;
      end

      if (w_fill_gnt) begin
        r_filled[w_fill_tgt] <= 1'b1;
        if (!r_filled[w_fill_tgt]) begin
          r_filled_cnt <= r_filled_cnt + CNT_ONE;
        end
        r_rr_ptr <= (w_fill_sel == SEL_LAST) ? '0 : (w_fill_sel + SEL_ONE);
      end else if (w_drain_gnt) begin
        r_filled[drain_idx] <= 1'b0;
        r_filled_cnt        <= r_filled_cnt - CNT_ONE;
      end

      // Count only drains that overtook a waiting fill; saturate at the limit.
      if (w_drain_gnt && w_fill_pend) begin
        if (r_starve_cnt != STARVE_MAX) begin
          r_starve_cnt <= r_starve_cnt + STARVE_ONE;
        end
      end else if (w_fill_gnt || !w_fill_pend) begin
        r_starve_cnt <= '0;
      end
    end
  end

  assign filled       = r_filled;
  assign filled_cnt   = r_filled_cnt;
  assign rd_data_vld  = r_rd_vld;
  assign rd_data_idx  = r_rd_idx;
  assign err_fill_dup = r_err_dup;

endmodule
